// File: rtl/register_bank.sv
// register_bank: NUM_REGS x WIDTH register store behind one shared tri-state bus port.
// Latency: loads/ops land at the next rising edge; the read path is combinational.
// Backpressure: none; every cycle accepts one load or op, and back-to-back ops accumulate.
module register_bank #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 4
) (
  input  logic             register_clock,
  input  logic             register_reset,
  input  logic [WIDTH-1:0] bus_bank_input,
  input  logic             bus_bank_input_en,
  input  logic [SEL_W-1:0] bus_bank_write_sel,
  input  logic [1:0]       bank_op,
  input  logic             bus_bank_out_en,
  input  logic [SEL_W-1:0] bus_bank_read_sel,
  output logic [WIDTH-1:0] bus_bank_output,
  output logic             bank_carry,
  output logic             bank_zero,
  output logic             bank_sel_err
);

  localparam logic [1:0]       OP_NONE = 2'b00;
  localparam logic [1:0]       OP_INC  = 2'b01;
  localparam logic [1:0]       OP_DEC  = 2'b10;
  localparam logic [1:0]       OP_CLR  = 2'b11;

  // One extra bit so NUM_REGS itself is representable when NUM_REGS == 2^SEL_W.
  localparam logic [SEL_W:0]   LP_NUM  = (SEL_W+1)'(NUM_REGS);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             r_carry;
  logic             r_zero;
  logic             r_sel_err;

  logic             w_wr_act;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_new;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_rd;

  assign w_wr_act      = bus_bank_input_en | (bank_op != OP_NONE);
  assign w_wr_in_range = {1'b0, bus_bank_write_sel} < LP_NUM;
  assign w_rd_in_range = {1'b0, bus_bank_read_sel} < LP_NUM;

  // Select current contents of the write target (old value feeding inc/dec).
  always_comb begin
    w_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus_bank_write_sel == SEL_W'(i)) w_old = r_regs[i];
    end
  end

  // Select read target; out-of-range indices fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus_bank_read_sel == SEL_W'(i)) w_rd = r_regs[i];
    end
  end

  // Next value and carry for the write target; a load always beats an op.
  always_comb begin
    w_new       = w_old;
    w_carry_nxt = 1'b0;
    if (bus_bank_input_en) begin
      w_new       = bus_bank_input;
      w_carry_nxt = 1'b0;
    end else begin
      case (bank_op)
        OP_INC: begin
          w_new       = w_old + 1'b1;
          w_carry_nxt = &w_old;
        end
        OP_DEC: begin
          w_new       = w_old - 1'b1;
          w_carry_nxt = ~|w_old;
        end
        OP_CLR: begin
          w_new       = '0;
          w_carry_nxt = 1'b0;
        end
        default: begin
          w_new       = w_old;
          w_carry_nxt = 1'b0;
        end
      endcase
    end
  end

  // Register array update: only the in-range write target changes.
  always_ff @(posedge register_clock) begin
    if (register_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_act && w_wr_in_range) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus_bank_write_sel == SEL_W'(i)) r_regs[i] <= w_new;
      end
    end
  end

  // Carry/zero describe the last in-range load or op; they hold otherwise.
  always_ff @(posedge register_clock) begin
    if (register_reset) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_wr_act && w_wr_in_range) begin
      r_carry <= w_carry_nxt;
      r_zero  <= (w_new == '0);
    end
  end

  // Select error: any bad access this cycle sets it, a clean access clears it, idle holds.
  always_ff @(posedge register_clock) begin
    if (register_reset) begin
      r_sel_err <= 1'b0;
    end else if ((w_wr_act && !w_wr_in_range) || (bus_bank_out_en && !w_rd_in_range)) begin
      r_sel_err <= 1'b1;
    end else if ((w_wr_act && w_wr_in_range) || (bus_bank_out_en && w_rd_in_range)) begin
      r_sel_err <= 1'b0;
    end
  end

  // Bus drive is released whenever the output enable is low; no write-through bypass.
  assign bus_bank_output = bus_bank_out_en ? w_rd : {WIDTH{1'bz}};
  assign bank_carry      = r_carry;
  assign bank_zero       = r_zero;
  assign bank_sel_err    = r_sel_err;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: a reference model pushes expected bus/flag values into a
// queue as each cycle is driven; they are popped and checked at the following falling edge.
// A weak pull-up on the bus makes a released (high-Z) bus read as all ones.
module tb_register_bank;

  localparam int NR = 4;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        in_en;
  logic [3:0]  wsel;
  logic [1:0]  op;
  logic        oe;
  logic [3:0]  rsel;
  wire  [15:0] w_bus;
  logic        carry;
  logic        zero;
  logic        sel_err;

  pullup (w_bus);

  register_bank #(.WIDTH(16), .NUM_REGS(NR), .SEL_W(4)) dut (
    .register_clock    (clk),
    .register_reset    (rst),
    .bus_bank_input    (din),
    .bus_bank_input_en (in_en),
    .bus_bank_write_sel(wsel),
    .bank_op           (op),
    .bus_bank_out_en   (oe),
    .bus_bank_read_sel (rsel),
    .bus_bank_output   (w_bus),
    .bank_carry        (carry),
    .bank_zero         (zero),
    .bank_sel_err      (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 bus, 1 carry, 2 zero, 3 sel_err
    logic [15:0] exp;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state
  logic [15:0] m[16];
  logic        m_carry, m_zero, m_err;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs(input int k);
    case (k)
      0:       return w_bus;
      1:       return {15'b0, carry};
      2:       return {15'b0, zero};
      default: return {15'b0, sel_err};
    endcase
  endfunction

  task automatic push(input string tag, input int k, input logic [15:0] e);
    exp_t x;
    x.tag  = tag;
    x.kind = k;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      chk(x.tag, obs(x.kind), x.exp);
    end
  endtask

  task automatic model_edge();
    logic        wact, win, rin;
    logic [15:0] old, nv;
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i] = 16'h0;
      m_carry = 1'b0;
      m_zero  = 1'b0;
      m_err   = 1'b0;
      return;
    end
    wact = in_en || (op != 2'b00);
    win  = (int'(wsel) < NR);
    rin  = (int'(rsel) < NR);
    if (wact && win) begin
      old = m[wsel];
      if (in_en) begin
        nv = din;
        m_carry = 1'b0;
      end else if (op == 2'b01) begin
        nv = old + 16'h1;
        m_carry = (old == 16'hFFFF);
      end else if (op == 2'b10) begin
        nv = old - 16'h1;
        m_carry = (old == 16'h0000);
      end else begin
        nv = 16'h0;
        m_carry = 1'b0;
      end
      m_zero  = (nv == 16'h0);
      m[wsel] = nv;
    end
    if ((wact && !win) || (oe && !rin)) m_err = 1'b1;
    else if ((wact && win) || (oe && rin)) m_err = 1'b0;
  endtask

  // One bus cycle: drive, expect the combinational bus value, check at negedge,
  // then apply the edge to the model and expect the resulting flags.
  task automatic cyc(input logic r, input logic ie, input logic [3:0] ws, input logic [15:0] d,
                     input logic [1:0] o, input logic e, input logic [3:0] rs, input string tag);
    logic [15:0] eb;
    rst = r; in_en = ie; wsel = ws; din = d; op = o; oe = e; rsel = rs;
    if (!e)                  eb = 16'hFFFF;
    else if (int'(rs) < NR)  eb = m[rs];
    else                     eb = 16'h0000;
    push({tag, "/bus"}, 0, eb);
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
    model_edge();
    push({tag, "/carry"}, 1, {15'b0, m_carry});
    push({tag, "/zero"},  2, {15'b0, m_zero});
    push({tag, "/err"},   3, {15'b0, m_err});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m[i] = 16'h0;
    m_carry = 1'b0; m_zero = 1'b0; m_err = 1'b0;
    rst = 1'b1; in_en = 1'b0; wsel = 4'h0; din = 16'h0; op = 2'b00; oe = 1'b0; rsel = 4'h0;

    // Reset, released bus, then zero reads of every register
    cyc(1, 0, 0, 16'h0, 2'b00, 0, 0, "rst");
    cyc(0, 0, 0, 16'h0, 2'b00, 0, 0, "hiz");
    for (int i = 0; i < NR; i++) cyc(0, 0, 0, 16'h0, 2'b00, 1, 4'(i), "rd0");

    // Load wins over a simultaneous increment
    cyc(0, 1, 2, 16'hA5A5, 2'b01, 1, 2, "ld_r2");
    for (int i = 0; i < NR; i++) cyc(0, 0, 0, 16'h0, 2'b00, 1, 4'(i), "chk_r2");

    // Wrap on increment and decrement
    cyc(0, 1, 1, 16'hFFFF, 2'b00, 1, 1, "ld_r1");
    cyc(0, 0, 1, 16'h0, 2'b01, 1, 1, "inc_r1");
    cyc(0, 0, 1, 16'h0, 2'b10, 1, 1, "dec_r1");
    cyc(0, 0, 0, 16'h0, 2'b00, 1, 1, "rd_r1");
    cyc(0, 0, 1, 16'h0, 2'b10, 1, 1, "dec2_r1");

    // Clear
    cyc(0, 0, 2, 16'h0, 2'b11, 1, 2, "clr_r2");
    cyc(0, 0, 0, 16'h0, 2'b00, 1, 2, "rd_r2");

    // Same-cycle read shows old value; back-to-back increments accumulate
    cyc(0, 1, 3, 16'h1234, 2'b00, 1, 3, "ld_r3");
    for (int i = 0; i < 4; i++) cyc(0, 0, 3, 16'h0, 2'b01, 1, 3, "inc_r3");
    cyc(0, 0, 0, 16'h0, 2'b00, 1, 3, "rd_r3");

    // Out-of-range select at the NUM_REGS boundary
    cyc(0, 1, 4, 16'h0001, 2'b00, 1, 0, "ld_oor");
    cyc(0, 0, 0, 16'h0, 2'b00, 0, 0, "idle_hold");
    cyc(0, 0, 0, 16'h0, 2'b00, 1, 4, "rd_oor");
    cyc(0, 0, 4, 16'h0, 2'b01, 0, 0, "inc_oor");
    for (int i = 0; i < NR; i++) cyc(0, 0, 0, 16'h0, 2'b00, 1, 4'(i), "chk_oor");
    cyc(0, 0, 0, 16'h0, 2'b00, 1, 15, "rd_oor15");
    cyc(0, 1, 0, 16'h0007, 2'b00, 0, 0, "ld_clr_err");
    cyc(0, 0, 0, 16'h0, 2'b00, 1, 0, "rd_r0");

    // Reset in the middle of an increment run
    cyc(0, 0, 0, 16'h0, 2'b01, 1, 0, "run_inc");
    cyc(0, 0, 0, 16'h0, 2'b01, 1, 0, "run_inc");
    cyc(1, 0, 0, 16'h0, 2'b01, 1, 0, "run_rst");
    cyc(0, 0, 0, 16'h0, 2'b00, 1, 0, "post_rst");
    cyc(0, 0, 0, 16'h0, 2'b00, 1, 0, "post_rst2");
    for (int i = 1; i < NR; i++) cyc(0, 0, 0, 16'h0, 2'b00, 1, 4'(i), "post_rst_rd");

    @(negedge clk);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
